// File: rtl/operand_fetch.sv
// Operand-fetch stage: 8 x 16-bit register file with write-port bypass on both
// read ports, registering A, B and the shift code toward the shifter behind valid/ready.
module operand_fetch #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AW-1:0]     rn,
  input  logic [AW-1:0]     rm,
  input  logic              bsel,
  input  logic [DATA_W-1:0] imm,
  input  logic [1:0]        shift_in,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [1:0]        shift_out
);

  logic [DATA_W-1:0] rf_q [NREGS];

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [1:0]        shift_q, shift_d;

  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic              accept;

  // The slot frees up either when empty or when its current set is consumed
  // this cycle; this is what allows one accept per cycle while streaming.
  assign req_ready = !out_valid_q || out_ready;
  assign accept    = req_valid && req_ready;

  // Read ports with bypass: a write landing this cycle is visible to the read.
  always_comb begin
    rd_a = rf_q[rn];
    if (wb_en && (wb_addr == rn)) begin
      rd_a = wb_data;
    end
    rd_b = rf_q[rm];
    if (wb_en && (wb_addr == rm)) begin
      rd_b = wb_data;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    out_valid_d = out_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    shift_d     = shift_q;
    if (accept) begin
      out_valid_d = 1'b1;
      a_d         = rd_a;
      b_d         = bsel ? imm : rd_b;
      shift_d     = shift_in;
    end else if (out_ready) begin
      // Operand fields keep their stale values; only the valid flag drops.
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next-state value from before the edge, independent of order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      shift_q     <= 2'b00;
    end else begin
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      shift_q     <= shift_d;
    end
  end

  // NOTE: the register file is reset entry by entry because architectural
  // registers must read 0 after reset; this keeps it in flops, not a RAM macro.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_en) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  assign out_valid = out_valid_q;
  assign a_out     = a_q;
  assign b_out     = b_q;
  assign shift_out = shift_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: the driver keeps a transaction-level model
// and queues expected operand sets; an independent monitor checks DUT output against the queue.
module tb_operand_fetch;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;
  localparam int AW     = 3;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [1:0]        sh;
  } op_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic [AW-1:0]     rn;
  logic [AW-1:0]     rm;
  logic              bsel;
  logic [DATA_W-1:0] imm;
  logic [1:0]        shift_in;
  logic              wb_en;
  logic [AW-1:0]     wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] b_out;
  logic [1:0]        shift_out;

  int checks   = 0;
  int failures = 0;

  // Reference state: architectural registers, whether a set is pending
  // downstream, and whether outputs must still be at their reset value.
  logic [DATA_W-1:0] m_regs [NREGS];
  logic              m_valid;
  logic              m_zero;
  op_t               exp_q [$];

  operand_fetch #(.DATA_W(DATA_W), .NREGS(NREGS), .AW(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .rn        (rn),
    .rm        (rm),
    .bsel      (bsel),
    .imm       (imm),
    .shift_in  (shift_in),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_out     (a_out),
    .b_out     (b_out),
    .shift_out (shift_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Evaluate one clock cycle of the model at the negedge, with inputs stable.
  task automatic step();
    op_t  e;
    logic rd_ok;
    @(negedge clk);
    check("req_ready", {31'd0, req_ready}, {31'd0, (!m_valid || out_ready)});
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    if (m_zero) begin
      check("a_out_reset", {16'd0, a_out}, 32'd0);
      check("b_out_reset", {16'd0, b_out}, 32'd0);
      check("shift_out_reset", {30'd0, shift_out}, 32'd0);
    end
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
      m_valid = 1'b0;
      m_zero  = 1'b1;
      exp_q.delete();
    end else begin
      rd_ok = !m_valid || out_ready;
      if (req_valid && rd_ok) begin
        e.a  = (wb_en && wb_addr == rn) ? wb_data : m_regs[rn];
        e.b  = bsel ? imm : ((wb_en && wb_addr == rm) ? wb_data : m_regs[rm]);
        e.sh = shift_in;
        exp_q.push_back(e);
        m_valid = 1'b1;
        m_zero  = 1'b0;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      if (wb_en) m_regs[wb_addr] = wb_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rv, input logic [AW-1:0] a_rn, input logic [AW-1:0] a_rm,
                       input logic a_bsel, input logic [DATA_W-1:0] a_imm, input logic [1:0] a_sh,
                       input logic a_wbe, input logic [AW-1:0] a_wba, input logic [DATA_W-1:0] a_wbd,
                       input logic a_ordy, input logic a_rst_n);
    req_valid = rv;
    rn        = a_rn;
    rm        = a_rm;
    bsel      = a_bsel;
    imm       = a_imm;
    shift_in  = a_sh;
    wb_en     = a_wbe;
    wb_addr   = a_wba;
    wb_data   = a_wbd;
    out_ready = a_ordy;
    reset_n   = a_rst_n;
    step();
  endtask

  task automatic idle(input logic a_ordy);
    drive(1'b0, 3'd0, 3'd0, 1'b0, 16'h0, 2'b00, 1'b0, 3'd0, 16'h0, a_ordy, 1'b1);
  endtask

  task automatic wb(input logic [AW-1:0] addr, input logic [DATA_W-1:0] data);
    drive(1'b0, 3'd0, 3'd0, 1'b0, 16'h0, 2'b00, 1'b1, addr, data, 1'b1, 1'b1);
  endtask

  // Monitor: whenever the DUT presents a set, it must equal the oldest expected one.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        check("a_out", {16'd0, a_out}, {16'd0, exp_q[0].a});
        check("b_out", {16'd0, b_out}, {16'd0, exp_q[0].b});
        check("shift_out", {30'd0, shift_out}, {30'd0, exp_q[0].sh});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [AW-1:0] r_rn, r_rm;
    req_valid = 1'b0; rn = '0; rm = '0; bsel = 1'b0; imm = '0; shift_in = 2'b00;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1; reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_valid = 1'b0;
    m_zero  = 1'b1;

    // Reset then idle: registers read as zero.
    idle(1'b1);
    drive(1'b1, 3'd3, 3'd5, 1'b0, 16'h0, 2'b00, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1);
    idle(1'b1);

    // Write then read.
    wb(3'd2, 16'h1234);
    wb(3'd7, 16'h8001);
    drive(1'b1, 3'd2, 3'd7, 1'b0, 16'h0, 2'b11, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1);
    idle(1'b1);

    // Same-cycle bypass on both ports.
    wb(3'd4, 16'h0001);
    drive(1'b1, 3'd4, 3'd4, 1'b0, 16'h0, 2'b01, 1'b1, 3'd4, 16'hBEEF, 1'b1, 1'b1);
    idle(1'b1);

    // Stall hold with a writeback to the held source, and a blocked request.
    drive(1'b1, 3'd2, 3'd7, 1'b0, 16'h0, 2'b10, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    drive(1'b1, 3'd1, 3'd1, 1'b0, 16'h0, 2'b00, 1'b1, 3'd2, 16'h5555, 1'b0, 1'b1);
    drive(1'b1, 3'd1, 3'd1, 1'b0, 16'h0, 2'b00, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    idle(1'b0);
    idle(1'b1);
    drive(1'b1, 3'd2, 3'd2, 1'b0, 16'h0, 2'b00, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1);
    idle(1'b1);

    // Immediate streaming, including a bypass hit on rm that must be ignored.
    drive(1'b1, 3'd7, 3'd3, 1'b1, 16'hFFF0, 2'b00, 1'b1, 3'd3, 16'hAAAA, 1'b1, 1'b1);
    drive(1'b1, 3'd7, 3'd3, 1'b1, 16'h0003, 2'b01, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1);
    drive(1'b1, 3'd7, 3'd3, 1'b1, 16'h7FFF, 2'b10, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1);
    drive(1'b1, 3'd7, 3'd3, 1'b1, 16'h8000, 2'b11, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1);
    idle(1'b1);

    // Reset in the middle of a stall.
    drive(1'b1, 3'd2, 3'd7, 1'b0, 16'h0, 2'b11, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    idle(1'b0);
    drive(1'b1, 3'd5, 3'd5, 1'b0, 16'h0, 2'b00, 1'b1, 3'd5, 16'h7777, 1'b0, 1'b0);
    drive(1'b1, 3'd2, 3'd5, 1'b0, 16'h0, 2'b00, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1);
    idle(1'b1);

    // Randomized traffic with biased register collisions and rare resets.
    for (int n = 0; n < 600; n++) begin
      r_rn = AW'($urandom_range(0, NREGS - 1));
      r_rm = ($urandom_range(0, 3) == 0) ? r_rn : AW'($urandom_range(0, NREGS - 1));
      drive(($urandom_range(0, 3) != 0), r_rn, r_rm, ($urandom_range(0, 3) == 0),
            16'($urandom), 2'($urandom),
            ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 2) == 0) ? r_rn : AW'($urandom_range(0, NREGS - 1)),
            16'($urandom), ($urandom_range(0, 2) != 0), ($urandom_range(0, 63) != 0));
    end

    // Drain and confirm every expected set was observed exactly once.
    repeat (3) idle(1'b1);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
Operand-fetch stage that sits directly upstream of the 16-bit datapath shifter. It holds the 8 x 16-bit register file and reads two source registers, A and B, per request. B may be replaced by an immediate. It registers A, B and the 2-bit shift code and presents them to the shifter/ALU through a valid/ready handshake with a 1-cycle latency. Writeback from the end of the datapath enters on a dedicated write port, with same-cycle read bypass.

Parameters:
DATA_W, 16, operand and register width
NREGS, 8, number of architectural registers
AW, 3, register address width (log2 NREGS)

Ports:
clk  input  1  single clock, all state changes on rising edge
reset_n  input  1  reset, synchronous, active-low
req_valid  input  1  upstream request valid
req_ready  output  1  stage can accept a request this cycle
rn  input  AW  source register for A
rm  input  AW  source register for B
bsel  input  1  1: B = imm; 0: B = R[rm]
imm  input  DATA_W  sign-extended immediate
shift_in  input  2  shift code forwarded to the shifter (00 pass, 01 lsl, 10 lsr, 11 asr)
wb_en  input  1  register write enable
wb_addr  input  AW  register write address
wb_data  input  DATA_W  register write data
out_valid  output  1  a_out/b_out/shift_out hold a valid operand set
out_ready  input  1  downstream consumes the operand set this cycle
a_out  output  DATA_W  registered A operand
b_out  output  DATA_W  registered B operand (feeds shifter input)
shift_out  output  2  registered shift code

Behaviour:
- Reset is synchronous and active-low: when reset_n = 0 at a rising clk edge, all NREGS registers become 0, out_valid = 0, a_out = 0, b_out = 0, shift_out = 00. Reset overrides any concurrent accept or writeback. Reset mid-stall discards the held operand set.
- req_ready = !out_valid || out_ready. This is combinational and has no dependency on req_valid.
- Accept = req_valid && req_ready. On accept, the next edge loads:
  - a_out = rdA
  - b_out = bsel ? imm : rdB
  - shift_out = shift_in
  - out_valid = 1
- rdA = (wb_en && wb_addr == rn) ? wb_data : R[rn]. rdB uses the same rule with rm. The bypass is combinational, so a same-cycle write is visible to the read.
- If there is no accept and out_ready = 1, out_valid clears at the next edge. a_out, b_out and shift_out keep their last values and are don't-care to consumers.
- Stall: while out_valid = 1 and out_ready = 0, a_out, b_out and shift_out must not change. Operands are a snapshot taken at accept; later writebacks do not update a held set.
- Back-to-back: if out_valid = 1, out_ready = 1 and req_valid = 1, the stage consumes and accepts in the same edge, so out_valid stays 1 and throughput is 1 per cycle.
- Writeback is independent of the handshake. When wb_en = 1, R[wb_addr] = wb_data at the edge, whether the stage is stalled, idle or accepting. Exactly one write per cycle.
- rn == rm is legal; A and B read the same value.
- When bsel = 1 the rm read is ignored, so a bypass hit on rm has no effect.
- No arithmetic is performed; widths pass through unchanged.
- All outputs are registered except req_ready.

Test Plan:
1. Reset then idle: reset_n = 0 for 2 cycles, then 1 -> out_valid = 0, a_out = b_out = 0, req_ready = 1. A request with rn = 3, rm = 5, bsel = 0 returns a_out = 0, b_out = 0.
2. Write then read: wb R2 = 0x1234, R7 = 0x8001. Next cycle request rn = 2, rm = 7, shift_in = 11 -> one cycle later out_valid = 1, a_out = 0x1234, b_out = 0x8001, shift_out = 11.
3. Same-cycle bypass: R4 = 0x0001, then in one cycle wb R4 = 0xBEEF and request rn = 4, rm = 4 -> a_out = b_out = 0xBEEF.
4. Stall hold: accept with rn = 2 (0x1234) while out_ready = 0 for 3 cycles, and write wb R2 = 0x5555 during the stall -> a_out stays 0x1234, req_ready = 0, out_valid = 1 throughout. On out_ready = 1 the set is consumed once. A new read of R2 returns 0x5555.
5. Immediate plus streaming: 4 consecutive requests with bsel = 1, imm = 0xFFF0, 0x0003, 0x7FFF, 0x8000 and out_ready held at 1 -> out_valid stays high 4 consecutive cycles, b_out follows that sequence one cycle late, no drops or duplicates.
6. Reset mid-stall: out_valid = 1, out_ready = 0, then assert reset_n = 0 for one cycle -> out_valid = 0, outputs 0, R2 reads back 0.
